sram_axi_responder: RTL

SRAM_AXI_RESPONDER -- requirements
Module: sram_axi_responder

---
 rtl/sram_axi_responder_pkg.sv | 24 ++
 rtl/sram_wstrb_gen.sv | 18 +
 rtl/sram_axi_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sram_axi_responder_pkg.sv
// Shared types and constants for the SRAM-like to AXI3 single-beat responder.
package sram_axi_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  // The undefined size code 3 is issued on the bus as a full word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? {1'b0, SIZE_WORD} : {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_wstrb_gen.sv
// Byte-lane write strobe from the SRAM-side size code and low address bits.
module sram_wstrb_gen
  import sram_axi_responder_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_responder.sv
// Bridges an SRAM-like request/response port onto AXI3, one single-beat transaction at a time.
module sram_axi_responder
  import sram_axi_responder_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  // SRAM-like side
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data (data bus prefixed to avoid clashing with the SRAM-side rdata)
  input  logic [3:0]  rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] axi_wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        aw_fire;
  logic        w_fire;

  // Response ids, codes and rlast carry no information for single-beat, error-tolerant use.
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, rresp, bresp, rlast};

  assign addr_ok = (state == IDLE);
  assign arvalid = (state == RD_AR);
  assign rready  = (state == RD_R);
  assign awvalid = (state == WR_AW_W) && !aw_done;
  assign wvalid  = (state == WR_AW_W) && !w_done;
  assign bready  = (state == WR_B);
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  assign rdata   = axi_rdata;
  assign data_ok = wr_reg ? (bready && bvalid) : (rready && rvalid);

  assign arid    = AXI_ID;
  assign araddr  = addr_reg;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axi_size(size_reg);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = AXI_ID;
  assign awaddr  = addr_reg;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = axi_size(size_reg);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid       = AXI_ID;
  assign axi_wdata = wdata_reg;
  assign wlast     = 1'b1;

  sram_wstrb_gen u_wstrb_gen (
    .size    (size_reg),
    .addr_lo (addr_reg[1:0]),
    .wstrb   (wstrb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            wr_reg    <= wr;
            size_reg  <= size;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            state     <= wr ? WR_AW_W : RD_AR;
          end
        end
        RD_AR:   if (arready) state <= RD_R;
        RD_R:    if (rvalid)  state <= IDLE;
        WR_AW_W: begin
          // Either channel may finish first; both finishing together also completes.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_B;
          end else begin
            aw_done <= aw_done || aw_fire;
            w_done  <= w_done || w_fire;
          end
        end
        WR_B:    if (bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
